par_serializer: RTL and testbench
=================================

# par_serializer

Upstream feeder for the serial parity-checking state machine. Accepts a parallel word on a single-cycle load, then shifts it out LSB-first one bit per clock on a single serial line. It can optionally append an even-parity bit. Framing and completion strobes let the downstream checker, or a bench, align on word boundaries.

## Interface
- WIDTH, default 8: data word width in bits; legal range 2..32.
- clk  input  1: single clock, rising edge.
- rst  input  1: asynchronous, active-low reset.
- load  input  1: request to accept `data`; honoured only while `ready`=1.
- data  input  WIDTH: parallel word, sampled on the accepting edge.
- ready  output  1: block idle and able to accept `load`.
- out  output  1: serial bit stream, registered; drives the checker's `in`.
- busy  output  1: high on every cycle `out` carries a frame bit.
- done  output  1: one-cycle pulse on the cycle after the last frame bit.

## Operation
- Reset values (while `rst`=0): state IDLE, `ready`=1, `out`=0, `busy`=0, `done`=0, shift register 0, bit counter 0.
- States: IDLE, SHIFT, PARITY (only with the macro), DONE.
- IDLE
  - `ready`=1, `out`=0.
  - If `load`=1 at a rising edge: capture `data` into the shift register, capture parity = XOR of all `data` bits, clear the counter, and go to SHIFT.
- SHIFT
  - `out`=shreg[0] and `busy`=1.
  - Each edge shifts shreg right by one, zero-filling, and increments the counter.
  - When the counter reaches WIDTH-1: go to PARITY if enabled, otherwise go to DONE.
- PARITY: `out`=captured parity bit, `busy`=1, then go to DONE.
- DONE: `out`=0, `busy`=0, `done`=1 for exactly one cycle, then go to IDLE.
- `load` outside IDLE is ignored and not queued. `data` is don't-care except on the accepting edge.
- Counter width is $clog2(WIDTH). The counter saturates at the terminal value and never wraps.
- If `rst` is asserted mid-frame, the frame is aborted immediately (asynchronously). Outputs return to their reset values. No `done` pulse is emitted and the partial frame is not resumed.
- Minimum spacing between accepted loads is frame length + 2 cycles (frame, then DONE, then IDLE).

## Timing
- All outputs are registered, with no combinational input-to-output path.
- Load accepted at edge k: bit 0 is on `out` during the cycle after edge k, and bit i is on `out` after edge k+i.
- Frame length F is WIDTH, or WIDTH+1 with parity enabled. `busy` is high for exactly F consecutive cycles.
- `done` is high in the cycle after edge k+F. `ready` rises in the cycle after edge k+F+1.
- Release of `rst` is synchronised by the environment; the block only requires that `rst` deassert away from a clock edge.

## Configuration
- Macro `PAR_SERIALIZER_PARITY_BIT_EN`.
- When defined:
  - the PARITY state exists and F=WIDTH+1;
  - the appended bit makes the total count of ones in the frame even.
- When undefined:
  - the PARITY state and the parity register are removed and F=WIDTH;
  - `done` follows the last data bit directly.

## Structure
- Shared package `par_pkg` holds:
  - the state enum typedef `par_ser_state_t`, with 2-bit encodings IDLE=0, SHIFT=1, PARITY=2, DONE=3;
  - constants `PAR_WIDTH_MIN`=2 and `PAR_WIDTH_MAX`=32.
- The downstream checker imports the same package.
- One sub-module: `par_parity_gen`, a purely combinational XOR reduction of a WIDTH-bit word, parameterised by WIDTH, reusable by the checker.
- The FSM, shift register and counter stay in `par_serializer`.

## Test plan
1. WIDTH=8, macro on, load 8'hA5 → `out` = 1,0,1,0,0,1,0,1 then parity 0. `busy` is high for 9 cycles, then one `done` pulse, then `ready`=1.
2. WIDTH=8, macro on, load 8'h07 → `out` = 1,1,1,0,0,0,0,0 then parity 1.
3. Pulse `load` with 8'hFF during bit 3 of an 8'h0F frame → the 8'h0F frame completes unchanged and 8'hFF is never transmitted.
4. Assert `rst` during bit 5 of an 8'hC3 frame → `out`=0, `busy`=0, `ready`=1 immediately, with no `done`. A new load of 8'h01 after release transmits 1,0,0,0,0,0,0,0 then parity 1.
5. Back-to-back: hold `load`=1 continuously with 8'h55 → frames start every F+2 cycles, and `out` carries 1,0,1,0,1,0,1,0 with parity 0 each time.
6. Macro off, WIDTH=4, load 4'b1001 → `out` = 1,0,0,1, `busy` is high for 4 cycles, and `done` appears on the 5th cycle after the accepting edge.

Source files
------------

// File: rtl/par_pkg.sv
// Shared types and limits for the serial parity feeder and its downstream checker.
package par_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StShift  = 2'd1,
    StParity = 2'd2,
    StDone   = 2'd3
  } par_ser_state_t;

  localparam int unsigned PAR_WIDTH_MIN = 2;
  localparam int unsigned PAR_WIDTH_MAX = 32;

  // Bit counter width for a WIDTH-bit word; never narrower than one bit.
  function automatic int unsigned par_cnt_width(int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/par_parity_gen.sv
// Combinational even-parity generator: XOR reduction of a WIDTH-bit word.
module par_parity_gen #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] word,
  output logic             parity
);

  assign parity = ^word;

endmodule

// File: rtl/par_serializer.sv
// Parallel-to-serial feeder, LSB first, registered outputs.
// Define PAR_SERIALIZER_PARITY_BIT_EN to append an even-parity bit after each word.
module par_serializer
  import par_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  output logic             ready,
  output logic             out,
  output logic             busy,
  output logic             done
);

  localparam int unsigned    CntW    = par_cnt_width(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  par_ser_state_t   state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
  logic             frame_last;

  assign frame_last = (cnt_q == CntLast);

`ifdef PAR_SERIALIZER_PARITY_BIT_EN
  logic parity_q, parity_d;
  logic data_parity;

  par_parity_gen #(
    .WIDTH(WIDTH)
  ) u_parity_gen (
    .word  (data),
    .parity(data_parity)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      shreg_q <= '0;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
`ifdef PAR_SERIALIZER_PARITY_BIT_EN
    parity_d = parity_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (load) begin
          state_d = StShift;
          shreg_d = data;
          cnt_d   = '0;
`ifdef PAR_SERIALIZER_PARITY_BIT_EN
          parity_d = data_parity;
`endif
        end
      end
      StShift: begin
        shreg_d = shreg_q >> 1;
        if (frame_last) begin
`ifdef PAR_SERIALIZER_PARITY_BIT_EN
          state_d = StParity;
`else
          state_d = StDone;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StParity: state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so they land in the register
  // aligned with the state they describe.
  always_comb begin
    out_d   = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    ready_d = 1'b0;
    unique case (state_d)
      StIdle: ready_d = 1'b1;
      StShift: begin
        out_d  = shreg_d[0];
        busy_d = 1'b1;
      end
      StParity: begin
`ifdef PAR_SERIALIZER_PARITY_BIT_EN
        out_d = parity_d;
`else
        out_d = 1'b0;
`endif
        busy_d = 1'b1;
      end
      StDone:  done_d = 1'b1;
      default: ready_d = 1'b0;
    endcase
  end

  assign out   = out_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign ready = ready_q;

endmodule

// File: tb/tb_par_serializer.sv
// Scoreboard bench for par_serializer: frame-timeline model plus bit/word queues.
module tb_par_serializer;

  localparam int W = 8;
`ifdef PAR_SERIALIZER_PARITY_BIT_EN
  localparam bit ParEn = 1'b1;
`else
  localparam bit ParEn = 1'b0;
`endif
  localparam int F = ParEn ? W + 1 : W;

  logic         clk = 1'b0;
  logic         rst;
  logic         load;
  logic [W-1:0] data;
  logic         ready;
  logic         out;
  logic         busy;
  logic         done;

  par_serializer #(
    .WIDTH(W)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .data (data),
    .ready(ready),
    .out  (out),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // phase: 0 idle, 1..F frame bit phase-1 on the line, F+1 done pulse.
  int         phase = 0;
  bit         bit_q[$];
  logic [W:0] frame_q[$];
  logic [W:0] rx = '0;
  int         rx_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Expected frame: data bits LSB first, then a bit making the count of ones even.
  function automatic logic [W:0] frame_of(input logic [W-1:0] d);
    int   ones;
    logic p;
    ones = 0;
    for (int i = 0; i < W; i++) ones += (d[i] == 1'b1) ? 1 : 0;
    p = ParEn && (ones % 2 == 1);
    return {p, d};
  endfunction

  // Reference model: decides acceptance and pushes expectations.
  always @(posedge clk or negedge rst) begin
    logic [W:0] fr;
    if (!rst) begin
      phase = 0;
      bit_q.delete();
      frame_q.delete();
    end else if (phase == 0) begin
      if (load) begin
        fr = frame_of(data);
        for (int i = 0; i < F; i++) bit_q.push_back(fr[i]);
        frame_q.push_back(fr);
        phase = 1;
      end
    end else if (phase == F + 1) begin
      phase = 0;
    end else begin
      phase++;
    end
  end

  // Monitor: samples on the falling edge, pops whenever the DUT presents data.
  always @(negedge clk) begin
    logic [W:0] fr;
    bit         b;
    if (!rst) begin
      rx     = '0;
      rx_cnt = 0;
    end else begin
      chk("busy", busy, (phase >= 1 && phase <= F));
      chk("done", done, (phase == F + 1));
      chk("ready", ready, (phase == 0));
      if (busy) begin
        checks++;
        if (bit_q.size() == 0) begin
          failures++;
          $display("FAIL out_bit: got busy with bit %0b, expected no frame bit at t=%0t",
                   out, $time);
        end else begin
          b = bit_q.pop_front();
          if (out !== b) begin
            failures++;
            $display("FAIL out_bit: got %0b, expected %0b at t=%0t", out, b, $time);
          end
        end
        if (rx_cnt <= W) rx[rx_cnt] = out;
        rx_cnt++;
      end else begin
        chk("out_idle", out, 1'b0);
      end
      if (done) begin
        checks++;
        if (frame_q.size() == 0) begin
          failures++;
          $display("FAIL frame_word: got done with %0h, expected no frame at t=%0t", rx, $time);
        end else begin
          fr = frame_q.pop_front();
          if (rx !== fr) begin
            failures++;
            $display("FAIL frame_word: got %0h, expected %0h at t=%0t", rx, fr, $time);
          end
        end
        chk("frame_len", rx_cnt, F);
        rx     = '0;
        rx_cnt = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 200 && phase != 0; n++) step();
  endtask

  task automatic send(input logic [W-1:0] d);
    wait_idle();
    load = 1'b1;
    data = d;
    step();
    load = 1'b0;
    data = W'($urandom);
  endtask

  initial begin
    rst  = 1'b1;
    load = 1'b0;
    data = '0;
    #1 rst = 1'b0;
    #1;
    chk("rst_out", out, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ready", ready, 1'b1);
    step();
    step();
    rst = 1'b1;
    step();

    send(8'hA5);
    send(8'h07);

    // Stray load during bit 3 must be dropped.
    send(8'h0F);
    repeat (3) step();
    load = 1'b1;
    data = 8'hFF;
    step();
    load = 1'b0;

    // Reset during bit 5 aborts the frame at once.
    send(8'hC3);
    repeat (5) step();
    rst = 1'b0;
    #1;
    chk("abort_out", out, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_ready", ready, 1'b1);
    chk("abort_done", done, 1'b0);
    step();
    step();
    rst = 1'b1;
    step();
    send(8'h01);

    // Load held high: frames every F+2 cycles.
    wait_idle();
    load = 1'b1;
    data = 8'h55;
    repeat (3 * (F + 2)) step();
    load = 1'b0;

    // Random load/data activity; the model decides what is accepted.
    repeat (400) begin
      load = ($urandom_range(0, 2) == 0);
      data = W'($urandom);
      step();
    end
    load = 1'b0;
    wait_idle();
    step();
    chk("bits_drained", bit_q.size(), 0);
    chk("frames_drained", frame_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
